// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide engine.
package muldiv_pkg;

  localparam int DEFAULT_XLEN = 32;

  // funct3 encodings of the M-extension ops
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL keeps only the low half, which is identical for signed and unsigned
  // operands, so it is handled on magnitudes without sign correction.
  function automatic logic is_signed_a(input md_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide on
// unsigned magnitudes. {hi,lo} holds the product, or remainder/quotient.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt,
  output logic            last
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;
  logic [XLEN-1:0] addend, rem_diff;
  logic [XLEN:0]   mul_sum, rem_sh;
  logic            rem_ge;

  // Compute one iteration step, or initialise the registers on load
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    addend   = lo_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, hi_q} + {1'b0, addend};
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    rem_ge   = rem_sh >= {1'b0, opnd_q};
    // The partial remainder is always below the divisor, so the difference fits XLEN bits.
    rem_diff = rem_sh[XLEN-1:0] - opnd_q;
    if (load) begin
      hi_d   = '0;
      lo_d   = div_mode ? a_mag : b_mag;
      opnd_d = div_mode ? b_mag : a_mag;
      cnt_d  = '0;
      div_d  = div_mode;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        hi_d = rem_ge ? rem_diff : rem_sh[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], rem_ge};
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

  // The final step's outcome is consumed in the same cycle it is computed
  assign hi_nxt = hi_d;
  assign lo_nxt = lo_d;
  assign last   = cnt_q == CW'(XLEN - 1);

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide engine: FSM, sign handling and special cases.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use one registered
// 2*XLEN multiply (IDLE -> DONE) instead of the iterative core.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d, op_in;
  logic              neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic              after_done_q, after_done_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              sa, sb, accept, div_zero, sgn_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, fast_res, core_res;
  logic              fast_en, core_load, core_step, core_last;
  logic [XLEN-1:0]   core_hi, core_lo;
  logic [2*XLEN-1:0] prod_s;

  // Decode the incoming op: magnitudes, sign flags and special-case results
  always_comb begin
    op_in    = md_op_e'(op);
    sa       = is_signed_a(op_in) & opa[XLEN-1];
    sb       = is_signed_b(op_in) & opb[XLEN-1];
    a_mag    = sa ? (~opa + XLEN'(1)) : opa;
    b_mag    = sb ? (~opb + XLEN'(1)) : opb;
    div_zero = is_div(op_in) && (opb == '0);
    sgn_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (opa == MIN_INT) && (opb == ALL_ONES);
    special  = div_zero | sgn_ovf;
    if (div_zero) special_res = is_rem(op_in) ? opa : ALL_ONES;
    else          special_res = is_rem(op_in) ? '0 : MIN_INT;
    // A start seen right after DONE still belongs to the retiring instruction.
    accept   = start & ~kill & ~after_done_q;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_signed;

  // Single-cycle multiply, captured into result_q on the way to DONE
  always_comb begin
    fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_signed = (sa ^ sb) ? (~fast_prod + (2*XLEN)'(1)) : fast_prod;
    fast_en     = ~is_div(op_in);
    fast_res    = (op_in == OP_MUL) ? fast_signed[XLEN-1:0] : fast_signed[2*XLEN-1:XLEN];
  end
`else
  assign fast_en  = 1'b0;
  assign fast_res = '0;
`endif

  // Apply the latched signs to the core's final step and select the output half
  always_comb begin
    prod_s = neg_q ? (~{core_hi, core_lo} + (2*XLEN)'(1)) : {core_hi, core_lo};
    case (op_q)
      OP_MUL:                       core_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: core_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              core_res = neg_q ? (~core_lo + XLEN'(1)) : core_lo;
      default:                      core_res = neg_rem_q ? (~core_hi + XLEN'(1)) : core_hi;
    endcase
  end

  // Next-state logic; kill overrides everything and suppresses any latch
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    neg_d        = neg_q;
    neg_rem_d    = neg_rem_q;
    result_d     = result_q;
    after_done_d = (state_q == DONE);
    core_load    = 1'b0;
    core_step    = 1'b0;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_d      = op_in;
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else if (fast_en) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            core_load = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          core_step = 1'b1;
          if (core_last) begin
            result_d = core_res;
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, and every flop uses <= so all update from pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_MUL;
      neg_q        <= 1'b0;
      neg_rem_q    <= 1'b0;
      after_done_q <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      neg_rem_q    <= neg_rem_d;
      after_done_q <= after_done_d;
      result_q     <= result_d;
    end
  end

  // Outputs: stall while accepting or iterating, done only in an unkilled DONE
  always_comb begin
    busy   = (state_q == BUSY) | ((state_q == IDLE) & accept);
    done   = (state_q == DONE) & ~kill;
    result = result_q;
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .div_mode (is_div(op_in)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .hi_nxt   (core_hi),
    .lo_nxt   (core_lo),
    .last     (core_last)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (both build configurations).
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] result;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .opa    (opa),
    .opb    (opb),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op with start held until done plus one cycle; operands are
  // scrambled after the start cycle to show only latched copies matter.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_busy);
    int          nbusy;
    logic        got;
    logic [31:0] res;
    nbusy = 0;
    got   = 1'b0;
    res   = '0;
    @(posedge clk); #1;
    start = 1'b1; op = f; opa = a; opb = b;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        res = result;
      end else if (busy) begin
        nbusy++;
      end
      if (i >= 1) begin
        opa = ~a; opb = ~b; op = ~f;
      end
    end
    check({tag, "_done"}, {31'b0, got}, 32'd1);
    check({tag, "_busy"}, nbusy, exp_busy);
    check({tag, "_res"}, res, exp);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_norestart"}, {30'b0, busy, done}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);

    run_op("mul_7_m3", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulhu_max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu_m1_2", F_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulh_min_sq", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
    run_op("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_5_0", F_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // kill in the start cycle: no stall and nothing latched
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; op = F_DIVU; opa = 32'd50; opb = 32'd5;
    @(negedge clk);
    check("kill_start_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("kill_start_idle", {30'b0, busy, done}, 32'd0);

    // kill while BUSY at cnt=10
    @(posedge clk); #1;
    start = 1'b1; op = F_DIVU; opa = 32'd1000; opb = 32'd3;
    repeat (11) @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    check("kill_busy_hold", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    @(negedge clk);
    check("kill_busy_drop", {30'b0, busy, done}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("kill_no_done", dones, 0);
    run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);

    // reset in the middle of a divide
    @(posedge clk); #1;
    start = 1'b1; op = F_DIVU; opa = 32'd100; opb = 32'd7;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);

    run_op("mul_6_7", F_MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
